// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one DW-bit ALU between two requesters.
//
// Requester 0 (execute stage) and requester 1 (address/aux unit) each present an
// operation through a valid/ready handshake. One operation is in flight at a time:
// accept (IDLE) -> drive ALU from registered operands (EXEC, one cycle) -> hold the
// registered result until the consumer takes it (RESP). Ties go round-robin.
// The NZCV register is updated only by operations with setf set.
//
// Ports:
//   clk, rst_n                       clock (rising edge), async active-low reset
//   reqN_valid / reqN_ready          request handshake, N = 0, 1
//   reqN_a, reqN_b, reqN_op          operands and ALU function select
//   reqN_cin, reqN_usec, reqN_setf   carry-in, use flag C as carry-in, update NZCV
//   alu_il, alu_ir, alu_if, alu_cin  to the ALU (always the operand registers)
//   alu_out, alu_cout, alu_v         from the ALU
//   rsp_valid / rsp_ready            response handshake
//   rsp_id, rsp_result, rsp_cout, rsp_v  registered response fields
//   flags                            NZCV register {N,Z,C,V}
module alu_share_arb #(
  parameter int unsigned DW        = 32,
  parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [3:0]    req0_op,
  input  logic          req0_cin,
  input  logic          req0_usec,
  input  logic          req0_setf,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [3:0]    req1_op,
  input  logic          req1_cin,
  input  logic          req1_usec,
  input  logic          req1_setf,
  output logic [DW-1:0] alu_il,
  output logic [DW-1:0] alu_ir,
  output logic [3:0]    alu_if,
  output logic          alu_cin,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_cout,
  input  logic          alu_v,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_result,
  output logic          rsp_cout,
  output logic          rsp_v,
  output logic [3:0]    flags
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e        state_q;
  logic          last_gnt_q;
  logic [DW-1:0] a_q, b_q;
  logic [3:0]    op_q;
  logic          cin_q, usec_q, setf_q, id_q;
  logic          rsp_valid_q, rsp_id_q, rsp_cout_q, rsp_v_q;
  logic [DW-1:0] rsp_result_q;
  logic [3:0]    flags_q;

  logic gnt_id;
  logic acc0, acc1, accept;

  // Grant: a lone valid wins; on a tie the requester that did not win last time wins.
  always_comb begin
    if (req0_valid && req1_valid) begin
      gnt_id = ~last_gnt_q;
    end else begin
      gnt_id = ~req0_valid;
    end
  end

  assign acc0   = (state_q == StIdle) & req0_valid & ~gnt_id;
  assign acc1   = (state_q == StIdle) & req1_valid & gnt_id;
  assign accept = acc0 | acc1;

  // Flops are held in reset anyway; gating here keeps ready low while rst_n is low.
  assign req0_ready = acc0 & rst_n;
  assign req1_ready = acc1 & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_gnt_q   <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      cin_q        <= 1'b0;
      usec_q       <= 1'b0;
      setf_q       <= 1'b0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_v_q      <= 1'b0;
      flags_q      <= FLAGS_RST;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            a_q        <= gnt_id ? req1_a    : req0_a;
            b_q        <= gnt_id ? req1_b    : req0_b;
            op_q       <= gnt_id ? req1_op   : req0_op;
            cin_q      <= gnt_id ? req1_cin  : req0_cin;
            usec_q     <= gnt_id ? req1_usec : req0_usec;
            setf_q     <= gnt_id ? req1_setf : req0_setf;
            id_q       <= gnt_id;
            last_gnt_q <= gnt_id;
            state_q    <= StExec;
          end
        end
        StExec: begin
          rsp_result_q <= alu_out;
          rsp_cout_q   <= alu_cout;
          rsp_v_q      <= alu_v;
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          if (setf_q) begin
            flags_q <= {alu_out[DW-1], (alu_out == '0), alu_cout, alu_v};
          end
          state_q <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Operand registers only change on accept, so the ALU sees stable inputs outside EXEC.
  assign alu_il  = a_q;
  assign alu_ir  = b_q;
  assign alu_if  = op_q;
  assign alu_cin = usec_q ? flags_q[1] : cin_q;

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_v      = rsp_v_q;
  assign flags      = flags_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req0_ready, req0_cin, req0_usec, req0_setf;
  logic [31:0] req0_a, req0_b;
  logic [3:0]  req0_op;
  logic        req1_valid, req1_ready, req1_cin, req1_usec, req1_setf;
  logic [31:0] req1_a, req1_b;
  logic [3:0]  req1_op;
  logic [31:0] alu_il, alu_ir, alu_out;
  logic [3:0]  alu_if;
  logic        alu_cin, alu_cout, alu_v;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_v;
  logic [31:0] rsp_result;
  logic [3:0]  flags;

  int total = 0;
  int bad   = 0;

  alu_share_arb #(.DW(32), .FLAGS_RST(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_cin(req0_cin), .req0_usec(req0_usec), .req0_setf(req0_setf),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_cin(req1_cin), .req1_usec(req1_usec), .req1_setf(req1_setf),
    .alu_il(alu_il), .alu_ir(alu_ir), .alu_if(alu_if), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_cout(rsp_cout), .rsp_v(rsp_v), .flags(flags)
  );

  always #5 clk = ~clk;

  // ALU stub: add with carry regardless of function select.
  always_comb begin
    {alu_cout, alu_out} = {1'b0, alu_il} + {1'b0, alu_ir} + {32'd0, alu_cin};
    alu_v = (alu_il[31] == alu_ir[31]) && (alu_out[31] != alu_il[31]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one operation in flight, phases free/executing/responding.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        cin;
    logic        usec;
    logic        setf;
    logic        id;
  } op_t;

  int          m_ph;      // 0 free, 1 executing, 2 holding response
  logic        m_last;
  logic [3:0]  m_flags;
  op_t         m_cur;
  logic [31:0] m_res;
  logic        m_cout, m_v, m_rid;
  logic        obs_r0, obs_r1;

  task automatic model_reset();
    m_ph = 0; m_last = 1'b1; m_flags = 4'b0000; m_cur = '0;
    m_res = '0; m_cout = 1'b0; m_v = 1'b0; m_rid = 1'b0;
  endtask

  // Called at posedge+1 with inputs already driven; checks, advances model, waits one cycle.
  task automatic step();
    logic   have, g, c_in;
    longint s;
    logic [32:0] u;
    #1;
    have = 1'b0; g = 1'b0;
    if (m_ph == 0) begin
      if (req0_valid && req1_valid) begin have = 1'b1; g = ~m_last; end
      else if (req0_valid)          begin have = 1'b1; g = 1'b0;    end
      else if (req1_valid)          begin have = 1'b1; g = 1'b1;    end
    end
    obs_r0 = req0_ready;
    obs_r1 = req1_ready;
    check("ready0", req0_ready, have && !g);
    check("ready1", req1_ready, have && g);
    c_in = m_cur.usec ? m_flags[1] : m_cur.cin;
    check("alu_il", alu_il, m_cur.a);
    check("alu_ir", alu_ir, m_cur.b);
    check("alu_if", alu_if, m_cur.op);
    check("alu_cin", alu_cin, c_in);
    check("rsp_valid", rsp_valid, m_ph == 2);
    check("rsp_id", rsp_id, m_rid);
    check("rsp_result", rsp_result, m_res);
    check("rsp_cout", rsp_cout, m_cout);
    check("rsp_v", rsp_v, m_v);
    check("flags", flags, m_flags);
    case (m_ph)
      0: if (have) begin
        m_cur = g ? '{req1_a, req1_b, req1_op, req1_cin, req1_usec, req1_setf, 1'b1}
                  : '{req0_a, req0_b, req0_op, req0_cin, req0_usec, req0_setf, 1'b0};
        m_last = g;
        m_ph = 1;
      end
      1: begin
        u = {1'b0, m_cur.a} + {1'b0, m_cur.b} + {32'd0, c_in};
        s = longint'($signed(m_cur.a)) + longint'($signed(m_cur.b)) + longint'(c_in);
        m_res = u[31:0];
        m_cout = u[32];
        m_v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        m_rid = m_cur.id;
        if (m_cur.setf) m_flags = {m_res[31], m_res == 32'd0, m_cout, m_v};
        m_ph = 2;
      end
      default: if (rsp_ready) m_ph = 0;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic v1, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic usec, input logic setf);
    req0_valid = v0; req1_valid = v1;
    req0_a = a; req0_b = b; req0_cin = cin; req0_usec = usec; req0_setf = setf;
    req1_a = a; req1_b = b; req1_cin = cin; req1_usec = usec; req1_setf = setf;
    req0_op = 4'h3; req1_op = 4'h5;
  endtask

  initial begin
    int nacc;
    drive(1'b1, 1'b1, 32'h1234, 32'h5678, 1'b1, 1'b0, 1'b1);
    rsp_ready = 1'b1;
    model_reset();
    #2;
    check("rst_ready0", req0_ready, 1'b0);
    check("rst_ready1", req1_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_result", rsp_result, 32'd0);
    check("rst_flags", flags, 4'b0000);
    check("rst_alu_il", alu_il, 32'd0);
    check("rst_alu_cin", alu_cin, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Both valid held: grants alternate 0,1,0,1, one accept every 3 cycles.
    nacc = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, $urandom, $urandom, 1'($urandom), 1'b0, 1'b0);
      step();
      if (obs_r0 || obs_r1) begin
        check("tie_order", obs_r1, nacc % 2);
        check("tie_spacing", i % 3, 0);
        nacc++;
      end
    end
    check("tie_count", nacc, 4);

    // Single request with latency check.
    drive(1'b1, 1'b0, 32'h0000000F, 32'h0000000F, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    check("single_valid", rsp_valid, 1'b1);
    check("single_id", rsp_id, 1'b0);
    check("single_result", rsp_result, 32'h0000001E);
    check("single_flags", flags, 4'b0000);
    step();

    // Carry chain through the C flag.
    drive(1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    check("cc_result", rsp_result, 32'h0);
    check("cc_flags", flags, 4'b0110);
    step();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    check("cc_alu_cin", alu_cin, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    check("cc_usec_result", rsp_result, 32'h00000001);
    step();

    // Overflow without flag update.
    drive(1'b1, 1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    check("ovf_result", rsp_result, 32'h80000000);
    check("ovf_v", rsp_v, 1'b1);
    check("ovf_flags", flags, 4'b0110);

    // Backpressure: response held, no accepts.
    rsp_ready = 1'b0;
    drive(1'b1, 1'b1, 32'h1, 32'h2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_result", rsp_result, 32'h80000000);
      check("bp_valid", rsp_valid, 1'b1);
      check("bp_noacc", obs_r0 | obs_r1, 1'b0);
    end
    rsp_ready = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    check("bp_release", rsp_valid, 1'b0);

    // Reset during EXEC aborts the operation.
    drive(1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b1, 1'b1, 32'h5, 32'h6, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mr_ready0", req0_ready, 1'b0);
    check("mr_ready1", req1_ready, 1'b0);
    check("mr_flags", flags, 4'b0000);
    check("mr_alu_il", alu_il, 32'd0);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("mr_no_rsp", rsp_valid, 1'b0);
    end
    rst_n = 1'b1;
    step();
    check("mr_tie_req0", obs_r0, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    step();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      req0_b = $urandom;
      req1_a = $urandom;
      req1_b = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom;
      req0_op = 4'($urandom); req1_op = 4'($urandom);
      req0_cin = 1'($urandom); req1_cin = 1'($urandom);
      req0_usec = 1'($urandom); req1_usec = 1'($urandom);
      req0_setf = 1'($urandom); req1_setf = 1'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
